// File: rtl/timer_ctrl.sv
// Bus register responder and trigger/interrupt controller for the timer block.
// Optional overflow counter register at 0x10 is enabled by defining TIMER_CTRL_OVFCNT_EN.
module timer_ctrl #(
  parameter int          ADDR_W     = 5,
  parameter int          TRIG_WIDTH = 1,
  parameter logic [31:0] RESET_TERM = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_valid,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic              bus_ready,
  output logic [31:0]       bus_rdata,
  output logic              bus_err,
  output logic              ro_trig_start,
  output logic              ro_trig_halt,
  output logic              ro_mode,
  output logic [31:0]       ro_termcount,
  input  logic              rf_status,
  input  logic [31:0]       rf_currcount,
  input  logic              rf_int,
  output logic              irq
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_TERM   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h0C);
`ifdef TIMER_CTRL_OVFCNT_EN
  localparam logic [ADDR_W-1:0] A_OVF    = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_TOP    = A_OVF;
`else
  localparam logic [ADDR_W-1:0] A_TOP    = A_STATUS;
`endif
  localparam logic [3:0] TRIG_LOAD = 4'(TRIG_WIDTH - 1);

  state_t      state, next_state;
  logic        accept;
  logic        req_err, wr_ok;
  logic [31:0] rd_data;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        ie;
  logic [31:0] term;
  logic [3:0]  start_cnt, halt_cnt;
  logic        start_req, halt_req;
  logic        rf_int_q, rf_int_q2, int_rise;
  logic        pending, w1c;
`ifdef TIMER_CTRL_OVFCNT_EN
  logic [7:0]  ovf_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (bus_valid) begin
        accept     = 1'b1;
        next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Misaligned or out-of-window accesses, and writes to read-only COUNT, error out.
  always_comb begin
    req_err = (bus_addr[1:0] != 2'b00) || (bus_addr > A_TOP) || (bus_we && bus_addr == A_COUNT);
    wr_ok   = accept && bus_we && !req_err;
    rd_data = 32'h0;
    if (!bus_we && !req_err) begin
      case (bus_addr)
        A_CTRL:   rd_data = {28'h0, ie, ro_mode, 2'b00};
        A_TERM:   rd_data = term;
        A_COUNT:  rd_data = rf_currcount;
        A_STATUS: rd_data = {30'h0, pending, rf_status};
`ifdef TIMER_CTRL_OVFCNT_EN
        A_OVF:    rd_data = {24'h0, ovf_cnt};
`endif
        default:  rd_data = 32'h0;
      endcase
    end
  end

  assign bus_ready    = (state == RESP);
  assign bus_rdata    = rdata_q;
  assign bus_err      = err_q;
  assign ro_termcount = term;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      ro_mode <= 1'b0;
      ie      <= 1'b0;
      term    <= RESET_TERM;
    end else begin
      if (accept) begin
        rdata_q <= rd_data;
        err_q   <= req_err;
      end else if (state == RESP) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
      if (wr_ok && bus_addr == A_CTRL) begin
        ro_mode <= bus_wdata[2];
        ie      <= bus_wdata[3];
      end
      if (wr_ok && bus_addr == A_TERM) term <= bus_wdata;
    end
  end

  // HALT takes priority; a request while the same pulse is active is dropped.
  assign start_req = wr_ok && bus_addr == A_CTRL && bus_wdata[0] && !bus_wdata[1];
  assign halt_req  = wr_ok && bus_addr == A_CTRL && bus_wdata[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ro_trig_start <= 1'b0;
      ro_trig_halt  <= 1'b0;
      start_cnt     <= 4'h0;
      halt_cnt      <= 4'h0;
    end else begin
      if (ro_trig_start) begin
        if (start_cnt == 4'h0) ro_trig_start <= 1'b0;
        else                   start_cnt     <= start_cnt - 4'h1;
      end else if (start_req) begin
        ro_trig_start <= 1'b1;
        start_cnt     <= TRIG_LOAD;
      end
      if (ro_trig_halt) begin
        if (halt_cnt == 4'h0) ro_trig_halt <= 1'b0;
        else                  halt_cnt     <= halt_cnt - 4'h1;
      end else if (halt_req) begin
        ro_trig_halt <= 1'b1;
        halt_cnt     <= TRIG_LOAD;
      end
    end
  end

  assign int_rise = rf_int_q && !rf_int_q2;
  assign w1c      = wr_ok && bus_addr == A_STATUS && bus_wdata[1];

  // A new interrupt event beats a simultaneous W1C so no event is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_int_q  <= 1'b0;
      rf_int_q2 <= 1'b0;
      pending   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      rf_int_q  <= rf_int;
      rf_int_q2 <= rf_int_q;
      if (int_rise) pending <= 1'b1;
      else if (w1c) pending <= 1'b0;
      irq <= pending && ie;
    end
  end

`ifdef TIMER_CTRL_OVFCNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_cnt <= 8'h0;
    end else if (w1c) begin
      ovf_cnt <= (int_rise && pending) ? 8'h1 : 8'h0;
    end else if (int_rise && pending && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'h1;
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard testbench for timer_ctrl: bus responses checked by a monitor against queued expectations.
// Honours TIMER_CTRL_OVFCNT_EN when the design is built with it.
module tb_timer_ctrl;

  localparam int TW = 4;

  logic        clk;
  logic        reset;
  logic        bus_valid;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        ro_trig_start;
  logic        ro_trig_halt;
  logic        ro_mode;
  logic [31:0] ro_termcount;
  logic        rf_status;
  logic [31:0] rf_currcount;
  logic        rf_int;
  logic        irq;

  logic [32:0] exp_q[$];
  int          total_checks;
  int          passed_checks;
  int          start_hi;
  int          halt_hi;
  logic        start_at_ready;
  logic        halt_at_ready;

  timer_ctrl #(.ADDR_W(5), .TRIG_WIDTH(TW), .RESET_TERM(32'h0)) dut (
    .clk(clk), .reset(reset),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .ro_trig_start(ro_trig_start), .ro_trig_halt(ro_trig_halt),
    .ro_mode(ro_mode), .ro_termcount(ro_termcount),
    .rf_status(rf_status), .rf_currcount(rf_currcount), .rf_int(rf_int),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task check_output(input string name, input logic [32:0] actual, input logic [32:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Monitor: every response strobe is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (ro_trig_start) start_hi++;
    if (ro_trig_halt)  halt_hi++;
    if (bus_ready === 1'b1) begin
      if (exp_q.size() == 0) check_output("unexpected_ready", 33'd1, 33'd0);
      else check_output("bus_resp", {bus_err, bus_rdata}, exp_q.pop_front());
    end
  end

  // Issues one transaction starting just after a rising edge; returns just after a rising edge.
  task automatic apply_stimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
    logic seen;
    exp_q.push_back({exp_err, exp_rdata});
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    @(posedge clk); #1;
    bus_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus_ready === 1'b1) begin
        seen           = 1'b1;
        start_at_ready = ro_trig_start;
        halt_at_ready  = ro_trig_halt;
      end
    end
    check_output("ready_seen", {32'h0, seen}, 33'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_int();
    @(posedge clk); #1 rf_int = 1'b1;
    @(posedge clk); #1 rf_int = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total_checks = 0; passed_checks = 0; start_hi = 0; halt_hi = 0;
    start_at_ready = 1'b0; halt_at_ready = 1'b0;
    reset = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    rf_status = 1'b0; rf_currcount = 32'h0; rf_int = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check_output("rst_irq",   {32'h0, irq}, 33'd0);
    check_output("rst_trig",  {31'h0, ro_trig_start, ro_trig_halt}, 33'd0);
    check_output("rst_ready", {32'h0, bus_ready}, 33'd0);
    check_output("rst_term",  {1'b0, ro_termcount}, 33'd0);
    apply_stimulus(1'b0, 5'h00, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h04, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0, 1'b0);

    // Start sequence
    apply_stimulus(1'b1, 5'h04, 32'h0000_0005, 32'h0, 1'b0);
    check_output("termcount", {1'b0, ro_termcount}, 33'h5);
    start_hi = 0; halt_hi = 0;
    apply_stimulus(1'b1, 5'h00, 32'h0000_000D, 32'h0, 1'b0);
    check_output("start_at_ready", {32'h0, start_at_ready}, 33'd1);
    check_output("mode_set", {32'h0, ro_mode}, 33'd1);
    repeat (8) @(posedge clk); #1;
    check_output("start_width", 33'(start_hi), 33'(TW));
    check_output("start_no_halt", 33'(halt_hi), 33'd0);
    apply_stimulus(1'b0, 5'h00, 32'h0, 32'h0000_000C, 1'b0);

    // Interrupt path
    @(posedge clk); #1 rf_int = 1'b1;
    @(posedge clk); #1 rf_int = 1'b0;
    check_output("irq_t0", {32'h0, irq}, 33'd0);
    @(posedge clk); #1;
    check_output("irq_t1", {32'h0, irq}, 33'd0);
    @(posedge clk); #1;
    check_output("irq_t2", {32'h0, irq}, 33'd1);
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0000_0002, 1'b0);
    apply_stimulus(1'b1, 5'h0C, 32'h0000_0002, 32'h0, 1'b0);
    check_output("irq_cleared", {32'h0, irq}, 33'd0);
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0, 1'b0);

    // Set lands in the same cycle as the W1C accept
    pulse_int();
    apply_stimulus(1'b1, 5'h0C, 32'h0000_0002, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0000_0002, 1'b0);

    // Simultaneous triggers and a retrigger during an active pulse
    start_hi = 0; halt_hi = 0;
    apply_stimulus(1'b1, 5'h00, 32'h0000_0003, 32'h0, 1'b0);
    check_output("halt_at_ready", {31'h0, halt_at_ready, start_at_ready}, 33'b10);
    apply_stimulus(1'b1, 5'h00, 32'h0000_0002, 32'h0, 1'b0);
    repeat (8) @(posedge clk); #1;
    check_output("halt_width", 33'(halt_hi), 33'(TW));
    check_output("halt_no_start", 33'(start_hi), 33'd0);
    check_output("mode_cleared", {32'h0, ro_mode}, 33'd0);
    check_output("irq_masked", {32'h0, irq}, 33'd0);
    rf_status = 1'b1;
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0000_0003, 1'b0);

    // Errors
    apply_stimulus(1'b0, 5'h06, 32'h0, 32'h0, 1'b1);
    apply_stimulus(1'b0, 5'h14, 32'h0, 32'h0, 1'b1);
    apply_stimulus(1'b1, 5'h08, 32'hFFFF_FFFF, 32'h0, 1'b1);
    rf_currcount = 32'h1234_5678;
    apply_stimulus(1'b0, 5'h08, 32'h0, 32'h1234_5678, 1'b0);
    apply_stimulus(1'b1, 5'h05, 32'h0000_FFFF, 32'h0, 1'b1);
    apply_stimulus(1'b0, 5'h04, 32'h0, 32'h0000_0005, 1'b0);

`ifdef TIMER_CTRL_OVFCNT_EN
    for (int i = 0; i < 300; i++) pulse_int();
    repeat (3) @(posedge clk); #1;
    apply_stimulus(1'b0, 5'h10, 32'h0, 32'h0000_00FF, 1'b0);
    apply_stimulus(1'b1, 5'h0C, 32'h0000_0002, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h10, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0000_0001, 1'b0);
`else
    apply_stimulus(1'b0, 5'h10, 32'h0, 32'h0, 1'b1);
`endif

    // Reset while a write is in flight: dropped, no response, registers back to reset values
    apply_stimulus(1'b1, 5'h00, 32'h0000_000C, 32'h0, 1'b0);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 5'h04; bus_wdata = 32'h0000_00AA;
    reset = 1'b0;
    @(posedge clk); #1 bus_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    rf_status = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_output("rst2_irq",  {32'h0, irq}, 33'd0);
    check_output("rst2_mode", {32'h0, ro_mode}, 33'd0);
    check_output("rst2_term", {1'b0, ro_termcount}, 33'd0);
    apply_stimulus(1'b0, 5'h00, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h04, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0, 1'b0);

    repeat (2) @(posedge clk); #1;
    check_output("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Bus-side register responder and controller for the timing block. It sits between the CPU memory-mapped bus and the timer.
- Drives the timer's ro_trig_start, ro_trig_halt, ro_mode and ro_termcount inputs.
- Samples the timer's rf_status, rf_currcount and rf_int outputs.
- Latches the rf_int pulse into a sticky pending flag and raises a maskable irq line to the core.

Parameters:
- ADDR_W, 5, byte-address width of the register window (minimum 5).
- TRIG_WIDTH, 1, clk cycles each trigger pulse is held high (legal range 1..15).
- RESET_TERM, 32'h0000_0000, reset value of the TERM register.

Ports:
- clk  input  1  master clock
- reset  input  1  synchronous, active-low reset
- bus_valid  input  1  request valid; held by the initiator until bus_ready
- bus_we  input  1  1 = write, 0 = read
- bus_addr  input  ADDR_W  byte address
- bus_wdata  input  32  write data
- bus_ready  output  1  one-cycle response strobe
- bus_rdata  output  32  read data; valid while bus_ready is high
- bus_err  output  1  error response, qualified by bus_ready
- ro_trig_start  output  1  start pulse to the timer
- ro_trig_halt  output  1  halt pulse to the timer
- ro_mode  output  1  1 = continuous, 0 = one-shot
- ro_termcount  output  32  terminal count
- rf_status  input  1  timer running
- rf_currcount  input  32  timer current count
- rf_int  input  1  timer terminal-count pulse, one clk wide
- irq  output  1  interrupt to the core (pending & IE)

Behaviour:
- Reset (reset == 0 at a clk edge) sets:
  - bus_ready = 0, bus_rdata = 0, bus_err = 0.
  - Both trigger outputs = 0 and pulse counters cleared.
  - MODE = 0, IE = 0, TERM = RESET_TERM, pending = 0, irq = 0.
  - FSM returns to IDLE; any in-flight transaction is dropped with no response.
- Register map (word aligned):
  - 0x00 CTRL: bit0 START (W, reads 0), bit1 HALT (W, reads 0), bit2 MODE (RW), bit3 IE (RW).
  - 0x04 TERM: RW, 32-bit.
  - 0x08 COUNT: RO; returns rf_currcount as sampled in the ACCEPT cycle.
  - 0x0C STATUS: bit0 = rf_status (RO), bit1 = pending (W1C).
  - All other bits read 0; writes to them are ignored.
- FSM states: IDLE, RESP.
  - IDLE -> RESP when bus_valid = 1. This is the accept cycle: write side effects are committed here and read data is captured.
  - RESP: bus_ready = 1 for exactly one cycle with bus_rdata/bus_err, then -> IDLE.
  - Latency is one cycle from accept to ready. The minimum back-to-back period is 2 cycles per transaction.
  - bus_valid is ignored while in RESP.
- Address errors: bus_addr[1:0] != 0, or an offset above 0x0C (0x10 when the optional feature is enabled), returns bus_err = 1 and rdata = 0, with no side effects.
- A write of 0x08 to COUNT returns bus_err = 1.
- Trigger pulses:
  - Writing CTRL with START = 1 drives ro_trig_start high starting the cycle after accept, for TRIG_WIDTH cycles, then low. HALT = 1 drives ro_trig_halt the same way.
  - The pulses are registered and glitch-free, because the timer is edge-sensitive on them.
  - If START and HALT are both 1 in the same write, HALT is issued and START is dropped.
  - A request for a trigger whose pulse is still active is ignored.
  - MODE and IE from the same write update in the accept cycle, so ro_mode is stable before the trigger edge.
- Interrupt:
  - rf_int is registered once, and a rising edge sets pending.
  - If the set and a W1C land in the same cycle, the set wins.
  - irq = pending & IE, registered.
  - Clearing IE masks irq but does not clear pending.
- ro_termcount follows TERM directly. A TERM write while the timer is running takes effect immediately; no shadowing.

Optional Feature:
- Macro: TIMER_CTRL_OVFCNT_EN.
- When defined:
  - Adds 0x10 OVF, an 8-bit RO register (bits [7:0]).
  - OVF counts rf_int rising edges that arrive while pending is already 1, saturating at 255.
  - Any W1C of STATUS bit1 also clears OVF; a simultaneous new event leaves OVF = 1.
- When undefined: 0x10 returns bus_err = 1 and no counter logic is present.

Test Plan:
- Reset state: hold reset = 0 for 3 cycles, then read 0x00, 0x04 and 0x0C -> rdata = 0, 0, 0; irq = 0; both triggers 0.
- Start sequence with TRIG_WIDTH = 1:
  - Write TERM = 0x0000_0005, then write CTRL = 0x0D -> ro_mode = 1 and IE = 1 from accept.
  - ro_trig_start is high for exactly 1 cycle, starting the cycle after accept.
  - bus_ready is high 1 cycle after accept.
- Interrupt path: drive rf_int high for 1 cycle -> STATUS reads 0x2 (bit0 follows rf_status) and irq = 1 two cycles later.
  - Write STATUS = 0x2 -> pending = 0 and irq = 0.
  - Repeat with rf_int in the same cycle as the W1C accept -> pending stays 1.
- Simultaneous triggers: write CTRL = 0x03 -> only ro_trig_halt pulses; ro_trig_start stays 0.
  - With TRIG_WIDTH = 4: a second HALT issued 2 cycles into the pulse is ignored, so the pulse lasts 4 cycles total.
- Errors:
  - Read 0x06 -> bus_err = 1, rdata = 0.
  - Write 0x08 -> bus_err = 1, and a following COUNT read still equals rf_currcount.
  - Assert reset = 0 during RESP -> no bus_ready, and all registers are at their reset values.
- TIMER_CTRL_OVFCNT_EN: set pending, then pulse rf_int 300 times -> OVF reads 255; W1C STATUS -> OVF reads 0.
